// File: rtl/pit_table.sv
// Pending Interest Table: records interests, forwards new ones to the FIB,
// buffers returning data packets and streams matched data back to spi_mcu.
module pit_table #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PREFIX_W   = 64,
  parameter int unsigned DATA_BYTES = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        SPI_to_PIT_bit,
  input  logic [$clog2(PREFIX_W)-1:0] SPI_to_PIT_length,
  input  logic [PREFIX_W-1:0]         SPI_to_PIT_prefix,
  output logic                        PIT_to_FIB_bit,
  output logic [$clog2(PREFIX_W)-1:0] PIT_to_FIB_length,
  output logic [PREFIX_W-1:0]         PIT_to_FIB_prefix,
  input  logic                        net_to_PIT_start,
  input  logic [PREFIX_W-1:0]         net_to_PIT_prefix,
  input  logic                        net_to_PIT_byte_valid,
  input  logic [7:0]                  net_to_PIT_byte,
  output logic                        PIT_to_SPI_bit,
  output logic [7:0]                  PIT_to_SPI_data,
  output logic [PREFIX_W-1:0]         PIT_to_SPI_prefix,
  output logic                        pit_full_drop,
  output logic                        data_drop
);

  localparam int unsigned LEN_W = $clog2(PREFIX_W);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned BUF_W = $clog2(DATA_BYTES);
  localparam int unsigned CNT_W = BUF_W + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MATCH  = 3'd1,
    S_DRAIN  = 3'd2,
    S_BUFFER = 3'd3,
    S_SEND   = 3'd4
  } state_e;

  // Top-L-bit prefix compare; a length of 0 means the full prefix width.
  function automatic logic prefix_eq(input logic [PREFIX_W-1:0] a,
                                     input logic [PREFIX_W-1:0] b,
                                     input logic [LEN_W-1:0]    len);
    logic [LEN_W:0]    eff;
    logic [PREFIX_W-1:0] mask;
    eff  = (len == '0) ? (LEN_W+1)'(PREFIX_W) : {1'b0, len};
    mask = ~({PREFIX_W{1'b1}} >> eff);
    return ((a ^ b) & mask) == '0;
  endfunction

  state_e              state_q, state_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    lock_q, lock_d;
  logic [LEN_W-1:0]    len_q [DEPTH];
  logic [PREFIX_W-1:0] pfx_q [DEPTH];
  logic [PREFIX_W-1:0] dpfx_q, dpfx_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          buf_q [DATA_BYTES];

  logic                fib_bit_q, fib_bit_d;
  logic [LEN_W-1:0]    fib_len_q, fib_len_d;
  logic [PREFIX_W-1:0] fib_pfx_q, fib_pfx_d;
  logic                full_drop_q, full_drop_d;
  logic                spi_bit_q, spi_bit_d;
  logic [7:0]          spi_data_q, spi_data_d;
  logic [PREFIX_W-1:0] spi_pfx_q, spi_pfx_d;
  logic                data_drop_q, data_drop_d;

  logic                int_hit_c;
  logic                free_any_c;
  logic [IDX_W-1:0]    free_idx_c;
  logic                dmatch_any_c;
  logic [IDX_W-1:0]    dmatch_idx_c;
  logic                ins_we_c;
  logic                buf_we_c;

  // Interest lookup: aggregate on equal-length match, else find lowest free entry.
  always_comb begin
    int_hit_c  = 1'b0;
    free_any_c = 1'b0;
    free_idx_c = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any_c = 1'b1;
        free_idx_c = IDX_W'(i);
      end
      if (valid_q[i] && (len_q[i] == SPI_to_PIT_length) &&
          prefix_eq(pfx_q[i], SPI_to_PIT_prefix, SPI_to_PIT_length)) begin
        int_hit_c = 1'b1;
      end
    end
  end

  // Data lookup: lowest-index valid, unlocked entry matching under its own length.
  always_comb begin
    dmatch_any_c = 1'b0;
    dmatch_idx_c = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && !lock_q[i] && prefix_eq(pfx_q[i], dpfx_q, len_q[i])) begin
        dmatch_any_c = 1'b1;
        dmatch_idx_c = IDX_W'(i);
      end
    end
  end

  // Next-state for the interest path, the data FSM and all registered outputs.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    lock_d      = lock_q;
    dpfx_d      = dpfx_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    ins_we_c    = 1'b0;
    buf_we_c    = 1'b0;
    fib_bit_d   = 1'b0;
    fib_len_d   = fib_len_q;
    fib_pfx_d   = fib_pfx_q;
    full_drop_d = 1'b0;
    spi_bit_d   = 1'b0;
    spi_data_d  = '0;
    spi_pfx_d   = spi_pfx_q;
    data_drop_d = 1'b0;

    if (SPI_to_PIT_bit && !int_hit_c) begin
      if (free_any_c) begin
        ins_we_c            = 1'b1;
        valid_d[free_idx_c] = 1'b1;
        fib_bit_d           = 1'b1;
        fib_len_d           = SPI_to_PIT_length;
        fib_pfx_d           = SPI_to_PIT_prefix;
      end else begin
        full_drop_d = 1'b1;
      end
    end

    if (net_to_PIT_start && (state_q != S_IDLE)) begin
      data_drop_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (net_to_PIT_start) begin
          dpfx_d  = net_to_PIT_prefix;
          state_d = S_MATCH;
        end
      end
      S_MATCH: begin
        cnt_d = '0;
        if (dmatch_any_c) begin
          lock_d[dmatch_idx_c] = 1'b1;
          sel_d                = dmatch_idx_c;
          state_d              = S_BUFFER;
        end else begin
          data_drop_d = 1'b1;
          state_d     = S_DRAIN;
        end
      end
      S_BUFFER: begin
        if (net_to_PIT_byte_valid) begin
          buf_we_c = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = S_SEND;
          end
        end
      end
      S_DRAIN: begin
        if (net_to_PIT_byte_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_SEND: begin
        if (cnt_q == '0) begin
          spi_bit_d = 1'b1;
          spi_pfx_d = pfx_q[sel_q];
          cnt_d     = CNT_W'(1);
        end else begin
          spi_data_d = buf_q[BUF_W'(cnt_q - CNT_W'(1))];
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_BYTES)) begin
            valid_d[sel_q] = 1'b0;
            lock_d[sel_q]  = 1'b0;
            cnt_d          = '0;
            state_d        = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      lock_q      <= '0;
      dpfx_q      <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      fib_bit_q   <= 1'b0;
      fib_len_q   <= '0;
      fib_pfx_q   <= '0;
      full_drop_q <= 1'b0;
      spi_bit_q   <= 1'b0;
      spi_data_q  <= '0;
      spi_pfx_q   <= '0;
      data_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      lock_q      <= lock_d;
      dpfx_q      <= dpfx_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      fib_bit_q   <= fib_bit_d;
      fib_len_q   <= fib_len_d;
      fib_pfx_q   <= fib_pfx_d;
      full_drop_q <= full_drop_d;
      spi_bit_q   <= spi_bit_d;
      spi_data_q  <= spi_data_d;
      spi_pfx_q   <= spi_pfx_d;
      data_drop_q <= data_drop_d;
    end
  end

  // Entry payload and packet buffer storage; qualified by valid, so no reset.
  always_ff @(posedge clk) begin
    if (ins_we_c && !rst) begin
      len_q[free_idx_c] <= SPI_to_PIT_length;
      pfx_q[free_idx_c] <= SPI_to_PIT_prefix;
    end
    if (buf_we_c && !rst) begin
      buf_q[BUF_W'(cnt_q)] <= net_to_PIT_byte;
    end
  end

  assign PIT_to_FIB_bit    = fib_bit_q;
  assign PIT_to_FIB_length = fib_len_q;
  assign PIT_to_FIB_prefix = fib_pfx_q;
  assign pit_full_drop     = full_drop_q;
  assign PIT_to_SPI_bit    = spi_bit_q;
  assign PIT_to_SPI_data   = spi_data_q;
  assign PIT_to_SPI_prefix = spi_pfx_q;
  assign data_drop         = data_drop_q;

endmodule

// File: tb/tb_pit_table.sv
// Self-checking bench for pit_table: directed scenarios plus a randomized
// interest/data mix against a table-level reference model.
module tb_pit_table;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 64;
  localparam int unsigned NB    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          SPI_to_PIT_bit = 1'b0;
  logic [5:0]    SPI_to_PIT_length = '0;
  logic [PW-1:0] SPI_to_PIT_prefix = '0;
  logic          PIT_to_FIB_bit;
  logic [5:0]    PIT_to_FIB_length;
  logic [PW-1:0] PIT_to_FIB_prefix;
  logic          net_to_PIT_start = 1'b0;
  logic [PW-1:0] net_to_PIT_prefix = '0;
  logic          net_to_PIT_byte_valid = 1'b0;
  logic [7:0]    net_to_PIT_byte = '0;
  logic          PIT_to_SPI_bit;
  logic [7:0]    PIT_to_SPI_data;
  logic [PW-1:0] PIT_to_SPI_prefix;
  logic          pit_full_drop;
  logic          data_drop;

  always #5 clk = ~clk;

  pit_table #(.DEPTH(DEPTH), .PREFIX_W(PW), .DATA_BYTES(NB)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .SPI_to_PIT_bit       (SPI_to_PIT_bit),
    .SPI_to_PIT_length    (SPI_to_PIT_length),
    .SPI_to_PIT_prefix    (SPI_to_PIT_prefix),
    .PIT_to_FIB_bit       (PIT_to_FIB_bit),
    .PIT_to_FIB_length    (PIT_to_FIB_length),
    .PIT_to_FIB_prefix    (PIT_to_FIB_prefix),
    .net_to_PIT_start     (net_to_PIT_start),
    .net_to_PIT_prefix    (net_to_PIT_prefix),
    .net_to_PIT_byte_valid(net_to_PIT_byte_valid),
    .net_to_PIT_byte      (net_to_PIT_byte),
    .PIT_to_SPI_bit       (PIT_to_SPI_bit),
    .PIT_to_SPI_data      (PIT_to_SPI_data),
    .PIT_to_SPI_prefix    (PIT_to_SPI_prefix),
    .pit_full_drop        (pit_full_drop),
    .data_drop            (data_drop)
  );

  int checks   = 0;
  int failures = 0;

  // Output monitor: counts pulses and assembles delivered packets.
  int                   drop_seen  = 0;
  int                   pfx_glitch = 0;
  logic [PW+NB*8-1:0]   pkt_q[$];
  logic                 mon_active = 1'b0;
  int                   mon_cnt    = 0;
  logic [PW-1:0]        mon_pfx    = '0;
  logic [NB*8-1:0]      mon_bytes  = '0;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (data_drop) drop_seen++;
      if (PIT_to_SPI_bit) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_pfx    = PIT_to_SPI_prefix;
        mon_bytes  = '0;
      end else if (mon_active) begin
        if (PIT_to_SPI_prefix !== mon_pfx) pfx_glitch++;
        mon_bytes[mon_cnt*8 +: 8] = PIT_to_SPI_data;
        mon_cnt++;
        if (mon_cnt == NB) begin
          pkt_q.push_back({mon_pfx, mon_bytes});
          mon_active = 1'b0;
        end
      end
    end
  end

  // Reference model of the table contents.
  logic          mv [DEPTH];
  logic [5:0]    ml [DEPTH];
  logic [PW-1:0] mp [DEPTH];

  function automatic bit m_match(input logic [PW-1:0] ep, input logic [5:0] el,
                                 input logic [PW-1:0] p);
    int e;
    e = (el == 6'd0) ? 64 : int'(el);
    if (e == 64) return ep == p;
    return (ep >> (64 - e)) == (p >> (64 - e));
  endfunction

  function automatic logic [PW-1:0] low_mask(input logic [5:0] el);
    int e;
    e = (el == 6'd0) ? 64 : int'(el);
    if (e == 64) return '0;
    return (64'h1 << (64 - e)) - 64'h1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    SPI_to_PIT_bit = 1'b0;
    net_to_PIT_start = 1'b0;
    net_to_PIT_byte_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    pkt_q.delete();
    for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
  endtask

  task automatic send_interest(input logic [5:0] len, input logic [PW-1:0] pfx);
    SPI_to_PIT_bit    = 1'b1;
    SPI_to_PIT_length = len;
    SPI_to_PIT_prefix = pfx;
    step();
    SPI_to_PIT_bit    = 1'b0;
  endtask

  task automatic drive_packet(input logic [PW-1:0] pfx, input logic [NB*8-1:0] payload,
                              input bit gaps, input int nbytes);
    net_to_PIT_start  = 1'b1;
    net_to_PIT_prefix = pfx;
    step();
    net_to_PIT_start  = 1'b0;
    step();
    for (int i = 0; i < nbytes; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        net_to_PIT_byte_valid = 1'b0;
        step();
      end
      net_to_PIT_byte_valid = 1'b1;
      net_to_PIT_byte       = payload[i*8 +: 8];
      step();
    end
    net_to_PIT_byte_valid = 1'b0;
  endtask

  task automatic wait_pkt(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (pkt_q.size() > 0) begin
        got = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if ({PIT_to_FIB_bit, PIT_to_FIB_length, PIT_to_FIB_prefix, PIT_to_SPI_bit,
         PIT_to_SPI_data, PIT_to_SPI_prefix, pit_full_drop, data_drop} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got fib=%0b spi=%0b data=%h drops=%0b%0b exp all 0",
               PIT_to_FIB_bit, PIT_to_SPI_bit, PIT_to_SPI_data, pit_full_drop, data_drop);
    end
    do_reset();
  endtask

  task automatic test_insert();
    logic [PW-1:0] a;
    a = 64'hABCD_0000_0000_0000;
    do_reset();
    send_interest(6'd16, a);
    checks++;
    if ({PIT_to_FIB_bit, PIT_to_FIB_length, PIT_to_FIB_prefix} !== {1'b1, 6'd16, a}) begin
      failures++;
      $display("FAIL insert_forward got bit=%0b len=%0d pfx=%h exp bit=1 len=16 pfx=%h",
               PIT_to_FIB_bit, PIT_to_FIB_length, PIT_to_FIB_prefix, a);
    end
    step();
    checks++;
    if ({PIT_to_FIB_bit, PIT_to_FIB_length, PIT_to_FIB_prefix} !== {1'b0, 6'd16, a}) begin
      failures++;
      $display("FAIL insert_hold got bit=%0b len=%0d pfx=%h exp bit=0 len=16 pfx=%h",
               PIT_to_FIB_bit, PIT_to_FIB_length, PIT_to_FIB_prefix, a);
    end
    send_interest(6'd16, a);
    checks++;
    if ({PIT_to_FIB_bit, pit_full_drop} !== 2'b00) begin
      failures++;
      $display("FAIL insert_aggregate got fib=%0b full=%0b exp 0 0", PIT_to_FIB_bit, pit_full_drop);
    end
    step();
  endtask

  task automatic test_fill();
    logic [PW-1:0] p;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      p = {8'(k + 1), 56'h0};
      send_interest(6'd8, p);
      checks++;
      if ({PIT_to_FIB_bit, PIT_to_FIB_prefix} !== {1'b1, p}) begin
        failures++;
        $display("FAIL fill_forward_%0d got bit=%0b pfx=%h exp bit=1 pfx=%h",
                 k, PIT_to_FIB_bit, PIT_to_FIB_prefix, p);
      end
    end
    send_interest(6'd8, 64'h0500_0000_0000_0000);
    checks++;
    if ({PIT_to_FIB_bit, pit_full_drop} !== 2'b01) begin
      failures++;
      $display("FAIL fill_full_drop got fib=%0b full=%0b exp 0 1", PIT_to_FIB_bit, pit_full_drop);
    end
    step();
    checks++;
    if (pit_full_drop !== 1'b0) begin
      failures++;
      $display("FAIL fill_drop_pulse got=%0b exp 0", pit_full_drop);
    end
    for (int k = 0; k < 4; k++) begin
      send_interest(6'd8, {8'(k + 1), 56'h0});
      checks++;
      if ({PIT_to_FIB_bit, pit_full_drop} !== 2'b00) begin
        failures++;
        $display("FAIL fill_kept_%0d got fib=%0b full=%0b exp 0 0", k, PIT_to_FIB_bit, pit_full_drop);
      end
    end
    step();
  endtask

  task automatic test_data_hit();
    logic [NB*8-1:0] pl;
    logic [PW-1:0]   a;
    int              g0;
    bit              got;
    a  = 64'hABCD_0000_0000_0000;
    for (int i = 0; i < NB; i++) pl[i*8 +: 8] = 8'(i);
    do_reset();
    send_interest(6'd16, a);
    step();
    g0 = pfx_glitch;
    drive_packet(64'hABCD_1234_5678_9ABC, pl, 1'b0, NB);
    wait_pkt(80, got);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL data_hit_timeout got no packet exp one");
    end else begin
      checks++;
      if (pkt_q[0] !== {a, pl}) begin
        failures++;
        $display("FAIL data_hit_payload got=%h exp=%h", pkt_q[0], {a, pl});
      end
      void'(pkt_q.pop_front());
    end
    checks++;
    if (pfx_glitch != g0) begin
      failures++;
      $display("FAIL data_hit_prefix_stable got glitches=%0d exp 0", pfx_glitch - g0);
    end
    step();
    checks++;
    if (PIT_to_SPI_data !== 8'h00) begin
      failures++;
      $display("FAIL data_hit_idle_data got=%h exp 00", PIT_to_SPI_data);
    end
    send_interest(6'd16, a);
    checks++;
    if (PIT_to_FIB_bit !== 1'b1) begin
      failures++;
      $display("FAIL data_hit_retired got fib=%0b exp 1", PIT_to_FIB_bit);
    end
    step();
  endtask

  task automatic test_data_miss();
    logic [NB*8-1:0] pl;
    int              d0;
    bit              got;
    for (int i = 0; i < NB; i++) pl[i*8 +: 8] = 8'(8'hA0 + i);
    do_reset();
    send_interest(6'd16, 64'hABCD_0000_0000_0000);
    step();
    d0 = drop_seen;
    drive_packet(64'h1111_1111_1111_1111, pl, 1'b1, NB);
    repeat (4) step();
    checks++;
    if (drop_seen - d0 != 1) begin
      failures++;
      $display("FAIL data_miss_drop got=%0d exp 1", drop_seen - d0);
    end
    checks++;
    if (pkt_q.size() != 0) begin
      failures++;
      $display("FAIL data_miss_no_send got=%0d exp 0", pkt_q.size());
    end
    drive_packet(64'hABCD_FFFF_0000_0000, pl, 1'b0, NB);
    wait_pkt(80, got);
    checks++;
    if (!got || pkt_q[0] !== {64'hABCD_0000_0000_0000, pl}) begin
      failures++;
      $display("FAIL data_miss_then_idle got packets=%0d exp 1 matching", pkt_q.size());
    end
    pkt_q.delete();
    step();
  endtask

  task automatic test_back_to_back();
    logic [NB*8-1:0] pl;
    int              d0;
    bit              seen;
    bit              got;
    for (int i = 0; i < NB; i++) pl[i*8 +: 8] = 8'($urandom);
    do_reset();
    for (int k = 0; k < 4; k++) send_interest(6'd8, {8'(k + 1), 56'h0});
    step();
    d0 = drop_seen;
    drive_packet(64'h01FF_0000_0000_0000, pl, 1'b1, NB);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (PIT_to_SPI_bit) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL b2b_send_start got no PIT_to_SPI_bit exp pulse");
      return;
    end
    repeat (3) step();
    net_to_PIT_start  = 1'b1;
    net_to_PIT_prefix = 64'h0200_0000_0000_0000;
    step();
    net_to_PIT_start  = 1'b0;
    repeat (27) step();
    send_interest(6'd8, 64'h7700_0000_0000_0000);
    checks++;
    if ({PIT_to_FIB_bit, pit_full_drop} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_retire_cycle got fib=%0b full=%0b exp 0 1", PIT_to_FIB_bit, pit_full_drop);
    end
    send_interest(6'd8, 64'h7700_0000_0000_0000);
    checks++;
    if ({PIT_to_FIB_bit, PIT_to_FIB_prefix} !== {1'b1, 64'h7700_0000_0000_0000}) begin
      failures++;
      $display("FAIL b2b_after_retire got fib=%0b pfx=%h exp 1 7700000000000000",
               PIT_to_FIB_bit, PIT_to_FIB_prefix);
    end
    wait_pkt(10, got);
    repeat (3) step();
    checks++;
    if (drop_seen - d0 != 1) begin
      failures++;
      $display("FAIL b2b_busy_drop got=%0d exp 1", drop_seen - d0);
    end
    checks++;
    if (pkt_q.size() != 1 || pkt_q[0] !== {64'h0100_0000_0000_0000, pl}) begin
      failures++;
      $display("FAIL b2b_stream_intact got packets=%0d exp 1 matching", pkt_q.size());
    end
    pkt_q.delete();
    send_interest(6'd8, 64'h0200_0000_0000_0000);
    checks++;
    if (PIT_to_FIB_bit !== 1'b0) begin
      failures++;
      $display("FAIL b2b_entry1_kept got fib=%0b exp 0", PIT_to_FIB_bit);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [NB*8-1:0] pl;
    logic [PW-1:0]   a;
    int              bad;
    bit              seen;
    a = 64'hABCD_0000_0000_0000;
    for (int i = 0; i < NB; i++) pl[i*8 +: 8] = 8'(8'h40 + i);
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      send_interest(6'd16, a);
      step();
      if (phase == 0) begin
        drive_packet(a, pl, 1'b0, 10);
      end else begin
        drive_packet(a, pl, 1'b0, NB);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
          step();
          if (PIT_to_SPI_bit) begin
            seen = 1'b1;
            break;
          end
        end
        checks++;
        if (!seen) begin
          failures++;
          $display("FAIL rst_mid_send_start got no PIT_to_SPI_bit exp pulse");
        end
        repeat (5) step();
      end
      rst = 1'b1;
      step();
      checks++;
      if ({PIT_to_FIB_bit, PIT_to_FIB_length, PIT_to_FIB_prefix, PIT_to_SPI_bit,
           PIT_to_SPI_data, PIT_to_SPI_prefix, pit_full_drop, data_drop} !== '0) begin
        failures++;
        $display("FAIL rst_mid_%0d_outputs got spi=%0b data=%h spfx=%h fpfx=%h exp all 0",
                 phase, PIT_to_SPI_bit, PIT_to_SPI_data, PIT_to_SPI_prefix, PIT_to_FIB_prefix);
      end
      rst = 1'b0;
      pkt_q.delete();
      bad = 0;
      for (int i = 0; i < 40; i++) begin
        net_to_PIT_byte_valid = (phase == 0);
        net_to_PIT_byte       = 8'hEE;
        step();
        if (PIT_to_SPI_bit !== 1'b0 || PIT_to_SPI_data !== 8'h00) bad++;
      end
      net_to_PIT_byte_valid = 1'b0;
      checks++;
      if (bad != 0 || pkt_q.size() != 0) begin
        failures++;
        $display("FAIL rst_mid_%0d_quiet got busy_cycles=%0d packets=%0d exp 0 0",
                 phase, bad, pkt_q.size());
      end
      send_interest(6'd16, a);
      checks++;
      if (PIT_to_FIB_bit !== 1'b1) begin
        failures++;
        $display("FAIL rst_mid_%0d_table_empty got fib=%0b exp 1", phase, PIT_to_FIB_bit);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [5:0]      len;
    logic [PW-1:0]   p;
    logic [NB*8-1:0] pl;
    int              hit;
    int              free;
    int              pick;
    int              d0;
    bit              got;
    do_reset();
    for (int op = 0; op < 40; op++) begin
      if ($urandom_range(0, 1) == 0) begin
        len = 6'($urandom_range(0, 63));
        p   = {$urandom, $urandom};
        pick = int'($urandom_range(0, DEPTH - 1));
        if ($urandom_range(0, 2) == 0 && mv[pick]) begin
          len = ml[pick];
          p   = (mp[pick] & ~low_mask(len)) | (p & low_mask(len));
        end
        hit = 0;
        free = -1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (!mv[i]) free = i;
          if (mv[i] && ml[i] == len && m_match(mp[i], len, p)) hit = 1;
        end
        send_interest(len, p);
        checks++;
        if (hit == 1) begin
          if ({PIT_to_FIB_bit, pit_full_drop} !== 2'b00) begin
            failures++;
            $display("FAIL rand_int_hit op=%0d got fib=%0b full=%0b exp 0 0", op, PIT_to_FIB_bit, pit_full_drop);
          end
        end else if (free >= 0) begin
          if ({PIT_to_FIB_bit, pit_full_drop, PIT_to_FIB_length, PIT_to_FIB_prefix} !== {2'b10, len, p}) begin
            failures++;
            $display("FAIL rand_int_new op=%0d got fib=%0b len=%0d pfx=%h exp 1 %0d %h",
                     op, PIT_to_FIB_bit, PIT_to_FIB_length, PIT_to_FIB_prefix, len, p);
          end
          mv[free] = 1'b1;
          ml[free] = len;
          mp[free] = p;
        end else begin
          if ({PIT_to_FIB_bit, pit_full_drop} !== 2'b01) begin
            failures++;
            $display("FAIL rand_int_full op=%0d got fib=%0b full=%0b exp 0 1", op, PIT_to_FIB_bit, pit_full_drop);
          end
        end
        step();
      end else begin
        p = {$urandom, $urandom};
        pick = int'($urandom_range(0, DEPTH - 1));
        if ($urandom_range(0, 2) != 0 && mv[pick]) begin
          p = (mp[pick] & ~low_mask(ml[pick])) | (p & low_mask(ml[pick]));
        end
        for (int w = 0; w < NB / 4; w++) pl[w*32 +: 32] = $urandom;
        hit = -1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (mv[i] && m_match(mp[i], ml[i], p)) hit = i;
        end
        d0 = drop_seen;
        drive_packet(p, pl, 1'b1, NB);
        if (hit >= 0) begin
          wait_pkt(80, got);
          checks++;
          if (!got || pkt_q[0] !== {mp[hit], pl} || drop_seen != d0) begin
            failures++;
            $display("FAIL rand_data_hit op=%0d got packets=%0d drops=%0d exp entry %0d pfx=%h",
                     op, pkt_q.size(), drop_seen - d0, hit, mp[hit]);
          end
          pkt_q.delete();
          mv[hit] = 1'b0;
        end else begin
          repeat (4) step();
          checks++;
          if (drop_seen - d0 != 1 || pkt_q.size() != 0) begin
            failures++;
            $display("FAIL rand_data_miss op=%0d got drops=%0d packets=%0d exp 1 0",
                     op, drop_seen - d0, pkt_q.size());
          end
        end
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_insert();
    test_fill();
    test_data_hit();
    test_data_miss();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pit_table.md
Name: pit_table

Overview:
- Pending Interest Table: sits between spi_mcu and the FIB/network side of the NDN router.
- Records interests decoded by spi_mcu and forwards new interests to the FIB; duplicate interests are aggregated.
- Buffers returning data packets and matches their prefix against pending entries.
- On a hit, streams the data back to spi_mcu over the PIT_to_SPI_* interface and retires the entry.

Parameters:
- DEPTH, 4, number of PIT entries (power of 2, 2..16).
- PREFIX_W, 64, prefix width in bits.
- DATA_BYTES, 32, payload bytes per data packet.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- SPI_to_PIT_bit  input  1  one-cycle pulse: interest valid.
- SPI_to_PIT_length  input  6  significant prefix bits L; 0 means 64.
- SPI_to_PIT_prefix  input  64  interest prefix, MSB-aligned.
- PIT_to_FIB_bit  output  1  one-cycle pulse: forward new interest.
- PIT_to_FIB_length  output  6  forwarded length.
- PIT_to_FIB_prefix  output  64  forwarded prefix.
- net_to_PIT_start  input  1  pulse: data packet header; prefix valid this cycle.
- net_to_PIT_prefix  input  64  data packet prefix.
- net_to_PIT_byte_valid  input  1  payload byte strobe.
- net_to_PIT_byte  input  8  payload byte, byte 0 first.
- PIT_to_SPI_bit  output  1  one-cycle pulse: data packet follows.
- PIT_to_SPI_data  output  8  payload byte stream.
- PIT_to_SPI_prefix  output  64  matched entry prefix.
- pit_full_drop  output  1  pulse: interest dropped, table full.
- data_drop  output  1  pulse: data packet unmatched, or arrived while busy.

Behaviour:
- Reset: all entries invalid; all outputs 0; data FSM in IDLE; counters 0. A reset mid-stream aborts the stream immediately and drives no further bytes.
- Entry contents: valid, length, prefix, lock.
- Match rule: entry matches prefix P when the top L bits of the entry prefix equal the top L bits of P (L = 0 is treated as 64).
- Interest path, registered, latency 1:
  - On SPI_to_PIT_bit, compare against all valid entries using the incoming prefix and the entry's length, requiring equal length.
  - Hit: aggregate, no forward, no state change.
  - Miss with a free entry: write the lowest-index free entry. Next cycle PIT_to_FIB_bit = 1 with length and prefix; those values hold until the next forward.
  - Miss with table full: pit_full_drop pulses next cycle.
  - Free entry means valid = 0 in registered state. An entry retired in the same cycle is not free until the following cycle.
- Data FSM states: IDLE, MATCH, DRAIN, BUFFER, SEND.
  - IDLE: on net_to_PIT_start, capture the prefix and go to MATCH.
  - MATCH (1 cycle): find the lowest-index valid matching entry.
    - Hit: set lock, record the index, clear the byte counter, go to BUFFER.
    - Miss: pulse data_drop, go to DRAIN.
  - BUFFER: on each net_to_PIT_byte_valid, store the byte at counter position and increment the counter. After DATA_BYTES bytes, go to SEND.
  - DRAIN: count and discard DATA_BYTES bytes, then go to IDLE.
  - SEND:
    - First cycle: PIT_to_SPI_bit = 1 and PIT_to_SPI_prefix = entry prefix.
    - Next DATA_BYTES consecutive cycles: PIT_to_SPI_data = byte 0 .. byte DATA_BYTES-1, one per cycle, no stalls.
    - PIT_to_SPI_prefix stays stable from the bit cycle through the last byte.
    - After the last byte: clear the entry's valid and lock, return to IDLE, PIT_to_SPI_data = 0.
- net_to_PIT_start outside IDLE: ignored; data_drop pulses.
- byte_valid in IDLE: ignored.
- Interest matching a locked entry: aggregated as a hit; it is satisfied by the in-flight data.
- Interest and data paths operate concurrently. Same-cycle SPI_to_PIT_bit and net_to_PIT_start are both serviced.
- Byte counter width is clog2(DATA_BYTES)+1 and never wraps within a packet.

Test Plan:
- Insert interest L=16, prefix 0xABCD_0000_0000_0000 -> PIT_to_FIB_bit pulse 1 cycle later with same length/prefix; entry 0 valid. Repeat the same interest -> no FIB pulse.
- Insert 4 distinct interests, then a 5th -> FIB pulses for the first 4; pit_full_drop pulses once for the 5th; no entry overwritten.
- With entry L=16 0xABCD..., data start prefix 0xABCD_1234_5678_9ABC plus 32 bytes 0x00..0x1F -> PIT_to_SPI_bit pulse, then 32 cycles of data 0x00..0x1F. Prefix 0xABCD_0000_0000_0000 is held throughout; entry invalid afterwards.
- Data prefix 0x1111... with no matching entry -> data_drop pulse in MATCH; 32 bytes consumed; no PIT_to_SPI_bit; FSM back in IDLE.
- Second net_to_PIT_start during SEND -> data_drop pulse; first stream completes intact. An interest arriving in the retire cycle takes a different free index or is dropped if full.
- Assert rst mid-BUFFER and mid-SEND -> all outputs 0 next cycle, table empty, no further bytes driven.
